// File: rtl/posit_weight_serializer_if.sv
// Parallel posit word input and serial weight output of the posit weight serializer.
// The serializer uses the master view; the weight buffer / multiplier side uses the slave view.
interface posit_weight_serializer_if #(
    parameter int unsigned MAX_W = 8
);
    logic [MAX_W-1:0] w_in;
    logic             w_in_valid;
    logic             w_in_ready;
    logic             w_out;
    logic             valid_out;
    logic             word_start;
    logic             word_last;

    modport master (
        input  w_in, w_in_valid,
        output w_in_ready, w_out, valid_out, word_start, word_last
    );

    modport slave (
        output w_in, w_in_valid,
        input  w_in_ready, w_out, valid_out, word_start, word_last
    );
endinterface

// File: rtl/posit_weight_serializer.sv
// Bit-serial posit (es = 0) weight transmitter: 2-entry input FIFO feeding an MSB-first shifter
// that streams back-to-back words without bubbles and owns the shared precision setting.
module posit_weight_serializer #(
    parameter int unsigned MAX_W = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            set,
    input  logic [3:0]                      precision,
    input  logic                            stall,
    output logic                            busy,
    posit_weight_serializer_if.master       bus
);
    localparam int unsigned IW    = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam logic [3:0]  MAX_P = 4'(MAX_W);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [3:0]       prec_q, prec_d;
    logic [MAX_W-1:0] fifo_q [2];
    logic [MAX_W-1:0] fifo_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       occ_q, occ_d;
    logic [MAX_W-1:0] sh_q, sh_d;
    logic [3:0]       rem_q, rem_d;
    logic             w_out_q, w_out_d;
    logic             valid_q, valid_d;
    logic             start_q, start_d;
    logic             last_q, last_d;

    logic             push, pop;
    logic [MAX_W-1:0] head, word_mask;
    logic [IW-1:0]    sign_idx, next_idx;

    assign bus.w_in_ready = (occ_q != 2'd2);
    assign bus.w_out      = w_out_q;
    assign bus.valid_out  = valid_q;
    assign bus.word_start = start_q;
    assign bus.word_last  = last_q;
    assign busy           = (occ_q != 2'd0) || (state_q == SHIFT) || valid_q;

    assign head      = fifo_q[rd_ptr_q];
    assign word_mask = {MAX_W{1'b1}} >> (MAX_P - prec_q);
    assign sign_idx  = IW'(prec_q - 4'd1);
    assign next_idx  = IW'(rem_q - 4'd1);
    assign push      = bus.w_in_valid && bus.w_in_ready;
    // A pop always coincides with emitting the next word's sign bit, so it also gates the stream.
    assign pop       = !stall && (occ_q != 2'd0) && ((state_q == IDLE) || (rem_q == 4'd0));

    always_comb begin
        state_d  = state_q;
        prec_d   = prec_q;
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        sh_d     = sh_q;
        rem_d    = rem_q;
        w_out_d  = w_out_q;
        valid_d  = 1'b0;
        start_d  = 1'b0;
        last_d   = 1'b0;
        occ_d    = occ_q + 2'(push) - 2'(pop);

        if (set && !busy) begin
            if (precision < 4'd2) begin
                prec_d = 4'd2;
            end else if (precision > MAX_P) begin
                prec_d = MAX_P;
            end else begin
                prec_d = precision;
            end
        end

        if (push) begin
            fifo_d[wr_ptr_q] = bus.w_in & word_mask;
            wr_ptr_d         = ~wr_ptr_q;
        end

        if (pop) begin
            state_d  = SHIFT;
            rd_ptr_d = ~rd_ptr_q;
            sh_d     = head;
            rem_d    = prec_q - 4'd1;
            w_out_d  = head[sign_idx];
            valid_d  = 1'b1;
            start_d  = 1'b1;
        end else if (!stall && (state_q == SHIFT)) begin
            if (rem_q != 4'd0) begin
                w_out_d = sh_q[next_idx];
                rem_d   = rem_q - 4'd1;
                valid_d = 1'b1;
                last_d  = (rem_q == 4'd1);
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            prec_q   <= 4'd2;
            fifo_q   <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
            sh_q     <= '0;
            rem_q    <= 4'd0;
            w_out_q  <= 1'b0;
            valid_q  <= 1'b0;
            start_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            prec_q   <= prec_d;
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            sh_q     <= sh_d;
            rem_q    <= rem_d;
            w_out_q  <= w_out_d;
            valid_q  <= valid_d;
            start_q  <= start_d;
            last_q   <= last_d;
        end
    end
endmodule

// File: tb/tb_posit_weight_serializer.sv
// Scoreboard bench for posit_weight_serializer: pushes enqueue the expected bit stream,
// a negedge monitor pops and compares every emitted bit and checks hold behaviour in gaps.
module tb_posit_weight_serializer;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       set = 1'b0;
    logic [3:0] precision = 4'd0;
    logic       stall_man = 1'b0;
    logic       stall_rnd = 1'b0;
    logic       rand_en = 1'b0;
    logic       stall;
    logic       busy;

    typedef struct packed {
        logic w;
        logic s;
        logic l;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   prec_m = 2;
    logic prev_w = 1'b0;

    posit_weight_serializer_if #(.MAX_W(8)) bus ();

    posit_weight_serializer #(.MAX_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .set       (set),
        .precision (precision),
        .stall     (stall),
        .busy      (busy),
        .bus       (bus)
    );

    assign stall = rand_en ? stall_rnd : stall_man;

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_set(input logic [3:0] p, input bit applies);
        precision = p;
        set = 1'b1;
        cyc();
        set = 1'b0;
        if (applies) prec_m = (p < 2) ? 2 : (p > 8) ? 8 : int'(p);
    endtask

    task automatic push(input logic [7:0] w, input bit exp_en);
        int unsigned t = 0;
        bus.w_in = w;
        bus.w_in_valid = 1'b1;
        while (!bus.w_in_ready && t < 100) begin
            cyc();
            t++;
        end
        check("push_ready_timeout", 32'(bus.w_in_ready), 32'd1);
        cyc();
        bus.w_in_valid = 1'b0;
        bus.w_in = '0;
        if (exp_en)
            for (int i = prec_m - 1; i >= 0; i--)
                sb.push_back('{w[i], (i == prec_m - 1), (i == 0)});
    endtask

    task automatic wait_idle(input string nm);
        int unsigned t = 0;
        while (busy && t < 500) begin
            @(negedge clk);
            t++;
        end
        check({nm, "_busy_drain"}, 32'(busy), 32'd0);
        check({nm, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic expect_valid(input string nm, input logic v);
        @(negedge clk);
        check(nm, 32'(bus.valid_out), 32'(v));
    endtask

    task automatic check_reset_vals(input string nm);
        check({nm, "_w_out"}, 32'(bus.w_out), 32'd0);
        check({nm, "_valid"}, 32'(bus.valid_out), 32'd0);
        check({nm, "_start"}, 32'(bus.word_start), 32'd0);
        check({nm, "_last"}, 32'(bus.word_last), 32'd0);
        check({nm, "_busy"}, 32'(busy), 32'd0);
        check({nm, "_ready"}, 32'(bus.w_in_ready), 32'd1);
    endtask

    // Monitor: every emitted bit must match the scoreboard head; gaps must hold w_out.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (bus.valid_out) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_bit: got w_out=%0b with empty scoreboard (t=%0t)",
                                 bus.w_out, $time);
                    end else begin
                        e = sb.pop_front();
                        check("stream_bit", 32'({bus.w_out, bus.word_start, bus.word_last}), 32'(e));
                    end
                end else begin
                    check("gap_hold", 32'({bus.w_out, bus.word_start, bus.word_last}),
                          32'({prev_w, 2'b00}));
                end
            end
            prev_w = bus.w_out;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            stall_rnd = ($urandom_range(0, 3) == 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.w_in = '0;
        bus.w_in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Precision 8, single word 0xB5: sign bit after the second edge, 8 contiguous bits.
        do_set(4'd8, 1'b1);
        push(8'hB5, 1'b1);
        expect_valid("t1_lead", 1'b0);
        repeat (8) expect_valid("t1_bits", 1'b1);
        @(negedge clk);
        check("t1_valid_end", 32'(bus.valid_out), 32'd0);
        check("t1_busy_end", 32'(busy), 32'd0);
        check("t1_sb_empty", 32'(sb.size()), 32'd0);

        // Precision 5, two words queued under stall, then 10 contiguous bits.
        do_set(4'd5, 1'b1);
        stall_man = 1'b1;
        push(8'h13, 1'b1);
        push(8'h0C, 1'b1);
        @(negedge clk);
        check("t2_full_ready", 32'(bus.w_in_ready), 32'd0);
        check("t2_full_busy", 32'(busy), 32'd1);
        stall_man = 1'b0;
        repeat (10) expect_valid("t2_bits", 1'b1);
        @(negedge clk);
        check("t2_valid_end", 32'(bus.valid_out), 32'd0);
        check("t2_busy_end", 32'(busy), 32'd0);
        check("t2_ready_end", 32'(bus.w_in_ready), 32'd1);

        // Precision 4, 0xA with two stalled edges inside the word.
        do_set(4'd4, 1'b1);
        push(8'h0A, 1'b1);
        expect_valid("t3_lead", 1'b0);
        expect_valid("t3_b1", 1'b1);
        stall_man = 1'b1;
        expect_valid("t3_gap1", 1'b0);
        expect_valid("t3_gap2", 1'b0);
        stall_man = 1'b0;
        repeat (3) expect_valid("t3_bits", 1'b1);
        @(negedge clk);
        check("t3_valid_end", 32'(bus.valid_out), 32'd0);
        check("t3_busy_end", 32'(busy), 32'd0);

        // Precision changes: ignored while busy, clamped low and high.
        push(8'h0F, 1'b1);
        cyc();
        do_set(4'd6, 1'b0);
        wait_idle("t4_inflight");
        push(8'h09, 1'b1);
        wait_idle("t4_still4");
        do_set(4'd6, 1'b1);
        push(8'h2D, 1'b1);
        wait_idle("t4_prec6");
        do_set(4'd1, 1'b1);
        push(8'h02, 1'b1);
        wait_idle("t4_clamp_lo");
        do_set(4'd12, 1'b1);
        push(8'h96, 1'b1);
        wait_idle("t4_clamp_hi");

        // Asynchronous reset after 3 of 8 bits with 2 words queued.
        do_set(4'd8, 1'b1);
        sb.push_back('{1'b1, 1'b1, 1'b0});
        sb.push_back('{1'b1, 1'b0, 1'b0});
        sb.push_back('{1'b0, 1'b0, 1'b0});
        push(8'hC3, 1'b0);
        push(8'h5A, 1'b0);
        push(8'h81, 1'b0);
        cyc();
        @(negedge clk);
        check("t5_pre_busy", 32'(busy), 32'd1);
        check("t5_pre_ready", 32'(bus.w_in_ready), 32'd0);
        check("t5_pre_sb", 32'(sb.size()), 32'd0);
        #1;
        rst = 1'b0;
        #1;
        check_reset_vals("t5_async");
        repeat (2) @(negedge clk);
        check_reset_vals("t5_held");
        @(posedge clk);
        #1;
        rst = 1'b1;
        prec_m = 2;
        push(8'hFF, 1'b1);
        wait_idle("t5_after");

        // 100 random words over random precisions with random stalls.
        rand_en = 1'b1;
        for (int b = 0; b < 10; b++) begin
            do_set(4'($urandom_range(3, 8)), 1'b1);
            for (int k = 0; k < 10; k++) push(8'($urandom_range(0, 255)), 1'b1);
            wait_idle("t6_random");
        end
        rand_en = 1'b0;

        check("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
